// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: opcodes, FSM states, default width.
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [4:0] {
    OpAdd    = 5'h00,
    OpSub    = 5'h01,
    OpAnd    = 5'h02,
    OpOr     = 5'h03,
    OpSll    = 5'h04,
    OpSlt    = 5'h05,
    OpSrl    = 5'h06,
    OpSltu   = 5'h07,
    OpXor    = 5'h08,
    OpSra    = 5'h09,
    OpMul    = 5'h10,
    OpMulh   = 5'h11,
    OpMulhsu = 5'h12,
    OpMulhu  = 5'h13,
    OpDiv    = 5'h14,
    OpDivu   = 5'h15,
    OpRem    = 5'h16,
    OpRemu   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StDone = 2'd2
  } alu_state_e;

  function automatic logic is_muldiv(logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between issue, the ALU and writeback.
interface alu_seq_if #(
  parameter int unsigned XLEN = alu_pkg::XLEN_DEFAULT
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_ctrl;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_res;
  logic            zero;

  modport master (
    output in_valid, alu_ctrl, src1, src2, out_ready,
    input  in_ready, out_valid, alu_res, zero
  );

  modport slave (
    input  in_valid, alu_ctrl, src1, src2, out_ready,
    output in_ready, out_valid, alu_res, zero
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle multiply (shift-add) / divide (restoring) engine on magnitudes,
// with sign fixup folded into the result of the final step.
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            iter,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] res
);
  localparam int unsigned CW = $clog2(XLEN);

  logic [2*XLEN-1:0] prod_q, prod_d, full;
  logic [XLEN-1:0]   mag_q, hi, lo, mag_a, mag_b, quo, rem;
  logic [XLEN:0]     sum, r_sh, diff;
  logic [4:0]        op_q;
  logic              neg_q, sa, sb, neg_start;
  logic [CW-1:0]     cnt_q;

  always_comb begin
    sa        = (op == OpMulh || op == OpMulhsu || op == OpDiv || op == OpRem) && a[XLEN-1];
    sb        = (op == OpMulh || op == OpDiv || op == OpRem) && b[XLEN-1];
    mag_a     = sa ? -a : a;
    mag_b     = sb ? -b : b;
    // Remainder follows the dividend; everything else follows the operand sign xor.
    neg_start = (op == OpRem || op == OpRemu) ? sa : (sa ^ sb);
  end

  // prod holds {product_hi, multiplier} for MUL*, {remainder, dividend/quotient} for DIV*.
  always_comb begin
    hi   = prod_q[2*XLEN-1:XLEN];
    lo   = prod_q[XLEN-1:0];
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag_q} : {(XLEN+1){1'b0}});
    r_sh = {hi, lo[XLEN-1]};
    diff = r_sh - {1'b0, mag_q};
    if (op_q[2]) begin
      prod_d = diff[XLEN] ? {r_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
    end else begin
      prod_d = {sum, lo[XLEN-1:1]};
    end
  end

  always_comb begin
    res  = '0;
    full = neg_q ? -prod_d : prod_d;
    quo  = prod_d[XLEN-1:0];
    rem  = prod_d[2*XLEN-1:XLEN];
    case (op_q)
      OpMul:                     res = full[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: res = full[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             res = neg_q ? -quo : quo;
      OpRem, OpRemu:             res = neg_q ? -rem : rem;
      default:                   res = '0;
    endcase
  end

  assign last = iter && (cnt_q == CW'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      mag_q  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      prod_q <= {{XLEN{1'b0}}, mag_a};
      mag_q  <= mag_b;
      op_q   <= op;
      neg_q  <= neg_start;
      cnt_q  <= '0;
    end else if (iter) begin
      prod_q <= prod_d;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with registered result. Define ALU_SEQ_MULDIV_EN to build
// the iterative M-extension engine; otherwise opcodes 0x10-0x17 return 0 in one cycle.
module alu_seq import alu_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] res_q, res_d, alu_res_c, a, b;
  logic [SHW-1:0]  shamt;
  logic            accept;

  assign a     = bus.src1;
  assign b     = bus.src2;
  assign shamt = b[SHW-1:0];

  assign bus.in_ready  = (state_q == StIdle) || (state_q == StDone && bus.out_ready);
  assign bus.out_valid = (state_q == StDone);
  assign bus.alu_res   = res_q;
  assign bus.zero      = (res_q == '0);
  assign accept        = bus.in_valid && bus.in_ready;

`ifdef ALU_SEQ_MULDIV_EN
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  logic            is_div_op, ovf, special, iter_op, start, last;
  logic [XLEN-1:0] eng_res;

  // Divide-by-zero and signed overflow resolve in one cycle from the single-cycle path.
  assign is_div_op = (bus.alu_ctrl[4:2] == 3'b101);
  assign ovf       = (bus.alu_ctrl == OpDiv || bus.alu_ctrl == OpRem) && a == MinInt && b == '1;
  assign special   = is_div_op && (b == '0 || ovf);
  assign iter_op   = is_muldiv(bus.alu_ctrl) && !special;

  alu_muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .iter  (state_q == StIter),
    .op    (bus.alu_ctrl),
    .a     (a),
    .b     (b),
    .last  (last),
    .res   (eng_res)
  );
`endif

  always_comb begin
    alu_res_c = '0;
    case (bus.alu_ctrl)
      OpAdd:  alu_res_c = a + b;
      OpSub:  alu_res_c = a + ~b + XLEN'(1);
      OpAnd:  alu_res_c = a & b;
      OpOr:   alu_res_c = a | b;
      OpXor:  alu_res_c = a ^ b;
      OpSll:  alu_res_c = a << shamt;
      OpSrl:  alu_res_c = a >> shamt;
      OpSra:  alu_res_c = $signed(a) >>> shamt;
      OpSlt:  alu_res_c = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu: alu_res_c = {{(XLEN-1){1'b0}}, a < b};
`ifdef ALU_SEQ_MULDIV_EN
      OpDiv, OpDivu: alu_res_c = (b == '0) ? '1 : a;
      OpRem, OpRemu: alu_res_c = (b == '0) ? a : '0;
`endif
      default: alu_res_c = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
`ifdef ALU_SEQ_MULDIV_EN
    start   = 1'b0;
`endif
    if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
      if (iter_op) begin
        start   = 1'b1;
        state_d = StIter;
      end else
`endif
      begin
        res_d   = alu_res_c;
        state_d = StDone;
      end
    end else begin
      case (state_q)
`ifdef ALU_SEQ_MULDIV_EN
        StIter: begin
          if (last) begin
            res_d   = eng_res;
            state_d = StDone;
          end
        end
`endif
        StDone: if (bus.out_ready) state_d = StIdle;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

endmodule
